ncc_peak_tracker: RTL and testbench
===================================

# ncc_peak_tracker

Downstream consumer of the 16×16 NCC processing-element array. For each window position it takes the array's 16 per-row accumulator outputs, sums them into one signed correlation score, and scans a SEARCH_W × SEARCH_H raster of positions. It reports the best score and its (x, y) coordinates through a valid/ready handshake. Its output feeds the feature-match / star-tracking logic.

## Interface
Parameters:
- SEARCH_W, 32: positions per search row (x range 0..SEARCH_W-1)
- SEARCH_H, 32: search rows (y range 0..SEARCH_H-1)
- ROWS, 16: number of row accumulators from the PE array
- ACC_W, 8: width of each row accumulator, two's complement

Ports (clock and reset first):
- clk  in  1  single clock; all logic posedge
- rst  in  1  reset, synchronous, active-high (one clock; reset is synchronous and active-high)
- start  in  1  one-cycle pulse that begins a new search
- accIn  in  ROWS×ACC_W  unpacked array [ROWS-1:0] of row accumulators
- in_valid  in  1  accIn holds the score for the next raster position
- in_ready  out  1  tracker accepts accIn this cycle
- result_valid  out  1  best_* fields are valid
- result_ready  in  1  consumer takes the result
- best_score  out  ACC_W+$clog2(ROWS)  signed best summed score
- best_x  out  $clog2(SEARCH_W)  column of best score
- best_y  out  $clog2(SEARCH_H)  row of best score

## Operation
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE: in_ready=0. On start, clear the x and y counters, set the internal best to the most negative SUM_W value, and go to ACCUM.
- ACCUM: in_ready=1. A beat is accepted when in_valid & in_ready.
  - Each accepted beat enters the adder pipeline tagged with the current (x, y).
  - x increments on every beat and wraps at SEARCH_W-1 to 0; y increments on that wrap.
  - After the beat at (SEARCH_W-1, SEARCH_H-1), go to DRAIN. in_ready is 0 from the next cycle.
- DRAIN: wait until the pipeline is empty, then go to DONE.
- DONE: result_valid=1, and best_* hold stable. When result_valid & result_ready, go to IDLE.
- Arithmetic:
  - Each accIn element is sign-extended to SUM_W = ACC_W+$clog2(ROWS).
  - Stage 1 sums four groups of 4 and registers them. Stage 2 sums the 4 partials and registers the total.
  - No overflow is possible at SUM_W.
- Compare stage: the best is replaced only if score > best (strict). Ties keep the earliest position in raster order.
- start during ACCUM or DRAIN aborts the search. The pipeline valid bits are flushed, counters and best are cleared, and the state is ACCUM.
- start in DONE is ignored.
- result_ready outside DONE is ignored.

## Timing
- Reset values: in_ready=0, result_valid=0, best_score=0, best_x=0, best_y=0, state=IDLE, pipeline valid bits=0.
- Reset asserted mid-search discards everything on the next edge.
- in_ready goes high the cycle after start is sampled in IDLE.
- Pipeline latency: accept edge, then stage 1 edge, stage 2 edge, and compare edge. The best register reflects a beat 3 edges after its acceptance.
- result_valid rises 3 cycles after the edge that accepted the final beat.
- result_valid falls on the edge where result_ready is sampled high. The next start is accepted no earlier than the following cycle.
- Throughput: one beat per cycle. Gaps in in_valid are allowed.
- Total search: SEARCH_W·SEARCH_H beats plus 3 cycles of drain.

## Configuration
- NCC_PEAK_THRESH_EN defined:
  - Adds input `thresh` (SUM_W, signed) and output `peak_found` (1).
  - `thresh` is sampled at start.
  - peak_found = (best_score >= thresh). It is valid with result_valid and reset to 0.
- NCC_PEAK_THRESH_EN undefined: neither port exists, and behaviour is otherwise identical.

## Test plan
- Single search, SEARCH_W=SEARCH_H=4: all accIn=0 except position (2,1), where all rows are 8'h05 -> best_score=80, best_x=2, best_y=1, result_valid 3 cycles after beat 15.
- Negative scores: every row = 8'hFF at all positions except (0,0), where every row = 8'hFE -> best_score=-16, best_x=1, best_y=0 (the first -16 occurs after (0,0), and ties keep the earliest).
- Backpressure: hold result_ready=0 for 20 cycles in DONE -> result_valid and best_* stable, in_ready=0 throughout; assert result_ready -> state is IDLE the next cycle.
- Abort: start mid-search after 7 beats, then a full clean raster with its peak at (3,3) -> result reports (3,3) only; the first search's peak is not reported.
- Reset in DRAIN -> next cycle result_valid=0, in_ready=0, outputs=0, and no result is produced later.
- With NCC_PEAK_THRESH_EN, thresh=100: a peak of 80 gives peak_found=0; a peak of 112 gives peak_found=1.

Source files
------------

// File: rtl/ncc_peak_tracker.sv
// ncc_peak_tracker
// Sums the ROWS per-row accumulators of the NCC PE array into one signed
// score per window position. It scans a SEARCH_W x SEARCH_H raster and reports
// the best (strictly greatest, earliest on ties) score and its coordinates.
//
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   start         : one-cycle pulse; begins a search (aborts one in progress)
//   accIn         : ROWS two's complement row accumulators
//   in_valid      : accIn carries the next raster position
//   in_ready      : tracker accepts accIn this cycle
//   result_valid  : best_* are valid (held until result_ready)
//   result_ready  : consumer takes the result
//   best_score    : best summed score, signed, ACC_W+$clog2(ROWS) bits
//   best_x/best_y : raster coordinates of best_score
// Optional feature, enabled by defining NCC_PEAK_THRESH_EN:
//   thresh        : signed threshold, sampled on start
//   peak_found    : best_score >= thresh, valid with result_valid
//
// Pipeline: input register (accept edge), group sums, total, compare.
module ncc_peak_tracker #(
    parameter int SEARCH_W = 32,
    parameter int SEARCH_H = 32,
    parameter int ROWS     = 16,
    parameter int ACC_W    = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [ACC_W-1:0]                       accIn [ROWS-1:0],
    input  logic                                   in_valid,
    output logic                                   in_ready,
`ifdef NCC_PEAK_THRESH_EN
    input  logic signed [ACC_W+$clog2(ROWS)-1:0]   thresh,
    output logic                                   peak_found,
`endif
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic signed [ACC_W+$clog2(ROWS)-1:0]   best_score,
    output logic [$clog2(SEARCH_W)-1:0]            best_x,
    output logic [$clog2(SEARCH_H)-1:0]            best_y
);
    localparam int SUM_W = ACC_W + $clog2(ROWS);
    localparam int XW    = $clog2(SEARCH_W);
    localparam int YW    = $clog2(SEARCH_H);
    localparam int GRP   = ROWS / 4;
    localparam logic signed [SUM_W-1:0] SUM_MIN = {1'b1, {(SUM_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t                  state_reg;
    logic                    in_ready_reg;
    logic                    result_valid_reg;
    logic [XW-1:0]           x_reg;
    logic [YW-1:0]           y_reg;

    // Pipeline registers with their valid bits and raster tags
    logic [ACC_W-1:0]        acc_reg [ROWS];
    logic                    v0_reg, v1_reg, v2_reg;
    logic [XW-1:0]           x0_reg, x1_reg, x2_reg;
    logic [YW-1:0]           y0_reg, y1_reg, y2_reg;
    logic signed [SUM_W-1:0] part_reg [4];
    logic signed [SUM_W-1:0] total_reg;

    // Running best and the registered result
    logic signed [SUM_W-1:0] best_reg;
    logic [XW-1:0]           bx_reg;
    logic [YW-1:0]           by_reg;
    logic signed [SUM_W-1:0] score_out_reg;
    logic [XW-1:0]           x_out_reg;
    logic [YW-1:0]           y_out_reg;

    logic signed [SUM_W-1:0] ext [ROWS];
    logic signed [SUM_W-1:0] part_next [4];
    logic signed [SUM_W-1:0] total_next;
    logic signed [SUM_W-1:0] best_next;
    logic [XW-1:0]           bx_next;
    logic [YW-1:0]           by_next;
    logic                    accept;
    logic                    last_pos;

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_ext
            assign ext[gi] = {{(SUM_W-ACC_W){acc_reg[gi][ACC_W-1]}}, acc_reg[gi]};
        end
    endgenerate

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            part_next[g] = '0;
            for (int k = 0; k < GRP; k++) begin
                part_next[g] = part_next[g] + ext[g*GRP + k];
            end
        end
    end

    assign total_next = part_reg[0] + part_reg[1] + part_reg[2] + part_reg[3];

    // Strict greater-than keeps the earliest position on ties
    always_comb begin
        best_next = best_reg;
        bx_next   = bx_reg;
        by_next   = by_reg;
        if (v2_reg && (total_reg > best_reg)) begin
            best_next = total_reg;
            bx_next   = x2_reg;
            by_next   = y2_reg;
        end
    end

    // A start pulse in ACCUM wins over a simultaneous beat
    assign accept   = in_valid && in_ready_reg && !start;
    assign last_pos = (x_reg == XW'(SEARCH_W-1)) && (y_reg == YW'(SEARCH_H-1));

`ifdef NCC_PEAK_THRESH_EN
    logic signed [SUM_W-1:0] thresh_reg;
    logic                    peak_found_reg;
    assign peak_found = peak_found_reg;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            in_ready_reg     <= 1'b0;
            result_valid_reg <= 1'b0;
            x_reg            <= '0;
            y_reg            <= '0;
            v0_reg           <= 1'b0;
            v1_reg           <= 1'b0;
            v2_reg           <= 1'b0;
            x0_reg           <= '0;
            y0_reg           <= '0;
            x1_reg           <= '0;
            y1_reg           <= '0;
            x2_reg           <= '0;
            y2_reg           <= '0;
            total_reg        <= '0;
            best_reg         <= '0;
            bx_reg           <= '0;
            by_reg           <= '0;
            score_out_reg    <= '0;
            x_out_reg        <= '0;
            y_out_reg        <= '0;
            for (int i = 0; i < 4; i++) part_reg[i] <= '0;
            for (int i = 0; i < ROWS; i++) acc_reg[i] <= '0;
`ifdef NCC_PEAK_THRESH_EN
            thresh_reg       <= '0;
            peak_found_reg   <= 1'b0;
`endif
        end else begin
            // Pipeline advances every cycle; valid bits mark live beats
            if (accept) begin
                for (int i = 0; i < ROWS; i++) acc_reg[i] <= accIn[i];
            end
            v0_reg    <= accept;
            x0_reg    <= x_reg;
            y0_reg    <= y_reg;
            v1_reg    <= v0_reg;
            x1_reg    <= x0_reg;
            y1_reg    <= y0_reg;
            for (int i = 0; i < 4; i++) part_reg[i] <= part_next[i];
            v2_reg    <= v1_reg;
            x2_reg    <= x1_reg;
            y2_reg    <= y1_reg;
            total_reg <= total_next;
            best_reg  <= best_next;
            bx_reg    <= bx_next;
            by_reg    <= by_next;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= ACCUM;
                        in_ready_reg <= 1'b1;
                        x_reg        <= '0;
                        y_reg        <= '0;
                        best_reg     <= SUM_MIN;
`ifdef NCC_PEAK_THRESH_EN
                        thresh_reg   <= thresh;
`endif
                    end
                end
                ACCUM, DRAIN: begin
                    if (start) begin
                        // Abort: flush live beats and restart the raster
                        state_reg    <= ACCUM;
                        in_ready_reg <= 1'b1;
                        v0_reg       <= 1'b0;
                        v1_reg       <= 1'b0;
                        v2_reg       <= 1'b0;
                        x_reg        <= '0;
                        y_reg        <= '0;
                        best_reg     <= SUM_MIN;
`ifdef NCC_PEAK_THRESH_EN
                        thresh_reg   <= thresh;
`endif
                    end else if (state_reg == ACCUM) begin
                        if (accept) begin
                            if (x_reg == XW'(SEARCH_W-1)) begin
                                x_reg <= '0;
                                y_reg <= y_reg + 1'b1;
                            end else begin
                                x_reg <= x_reg + 1'b1;
                            end
                            if (last_pos) begin
                                state_reg    <= DRAIN;
                                in_ready_reg <= 1'b0;
                            end
                        end
                    end else if (!v0_reg && !v1_reg) begin
                        // Last beat is in the compare stage this edge
                        state_reg        <= DONE;
                        result_valid_reg <= 1'b1;
                        score_out_reg    <= best_next;
                        x_out_reg        <= bx_next;
                        y_out_reg        <= by_next;
`ifdef NCC_PEAK_THRESH_EN
                        peak_found_reg   <= (best_next >= thresh_reg);
`endif
                    end
                end
                DONE: begin
                    if (result_ready) begin
                        state_reg        <= IDLE;
                        result_valid_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_reg;
    assign result_valid = result_valid_reg;
    assign best_score   = score_out_reg;
    assign best_x       = x_out_reg;
    assign best_y       = y_out_reg;

endmodule

// File: tb/tb_ncc_peak_tracker.sv
// Directed bench for ncc_peak_tracker on a 4x4 raster.
module tb_ncc_peak_tracker;
    localparam int SW = 4;
    localparam int SH = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [7:0]        acc_in [15:0];
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              result_valid;
    logic              result_ready = 1'b0;
    logic signed [11:0] best_score;
    logic [1:0]        best_x;
    logic [1:0]        best_y;
`ifdef NCC_PEAK_THRESH_EN
    logic signed [11:0] thresh = 12'sd100;
    logic              peak_found;
`endif

    int tests = 0;
    int fails = 0;

    ncc_peak_tracker #(.SEARCH_W(SW), .SEARCH_H(SH), .ROWS(16), .ACC_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .accIn        (acc_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
`ifdef NCC_PEAK_THRESH_EN
        .thresh       (thresh),
        .peak_found   (peak_found),
`endif
        .result_valid (result_valid),
        .result_ready (result_ready),
        .best_score   (best_score),
        .best_x       (best_x),
        .best_y       (best_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds n beats; position (px,py) carries pv in every row, others bv.
    // gap_at inserts one idle cycle before that beat.
    task automatic feed(input int px, input int py, input logic [7:0] pv,
                        input logic [7:0] bv, input int n, input int gap_at);
        for (int b = 0; b < n; b++) begin
            int g;
            if (b == gap_at) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            for (int r = 0; r < 16; r++)
                acc_in[r] = ((b % SW) == px && (b / SW) == py) ? pv : bv;
            in_valid = 1'b1;
            g = 0;
            while (!in_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            if (g == 20) check("in_ready_timeout", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result();
        int g = 0;
        while (!result_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g == 20) check("result_timeout", result_valid, 1);
    endtask

    task automatic take_result();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("rv_after_take", result_valid, 0);
    endtask

    initial begin
        for (int r = 0; r < 16; r++) acc_in[r] = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", in_ready, 0);
        check("reset_rv", result_valid, 0);
        check("reset_score", best_score, 0);
        check("reset_x", best_x, 0);
        check("reset_y", best_y, 0);

        // Single peak of 5 per row at (2,1), with an in_valid gap
        pulse_start();
        check("t1_in_ready_after_start", in_ready, 1);
        feed(2, 1, 8'h05, 8'h00, 16, 5);
        check("t1_in_ready_drain", in_ready, 0);
        check("t1_rv_lat0", result_valid, 0);
        @(negedge clk);
        check("t1_rv_lat1", result_valid, 0);
        @(negedge clk);
        check("t1_rv_lat2", result_valid, 0);
        @(negedge clk);
        check("t1_rv_lat3", result_valid, 1);
        check("t1_score", best_score, 80);
        check("t1_x", best_x, 2);
        check("t1_y", best_y, 1);

        // Backpressure in DONE for 20 cycles; a start here is ignored
        for (int c = 0; c < 20; c++) begin
            if (c == 5) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("bp_rv", result_valid, 1);
            check("bp_score", best_score, 80);
            check("bp_x", best_x, 2);
            check("bp_y", best_y, 1);
            check("bp_in_ready", in_ready, 0);
        end
        take_result();
        check("idle_in_ready", in_ready, 0);
        @(negedge clk);
        check("idle_in_ready2", in_ready, 0);
        check("idle_rv", result_valid, 0);

        // Negative scores: (0,0) is -32, everything else -16
        pulse_start();
        feed(0, 0, 8'hFE, 8'hFF, 16, -1);
        wait_result();
        check("neg_score", best_score, -16);
        check("neg_x", best_x, 1);
        check("neg_y", best_y, 0);
        take_result();

        // Abort after 7 beats (large peak at (1,0)), then clean raster
        pulse_start();
        feed(1, 0, 8'h7F, 8'h00, 7, -1);
        check("abort_rv", result_valid, 0);
        pulse_start();
        check("abort_in_ready", in_ready, 1);
        feed(3, 3, 8'h03, 8'h00, 16, -1);
        wait_result();
        check("abort_score", best_score, 48);
        check("abort_x", best_x, 3);
        check("abort_y", best_y, 3);
        take_result();

        // Reset during drain discards the search
        pulse_start();
        feed(1, 2, 8'h09, 8'h00, 16, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstd_rv", result_valid, 0);
        check("rstd_in_ready", in_ready, 0);
        check("rstd_score", best_score, 0);
        check("rstd_x", best_x, 0);
        check("rstd_y", best_y, 0);
        repeat (10) @(negedge clk);
        check("rstd_rv_later", result_valid, 0);

`ifdef NCC_PEAK_THRESH_EN
        thresh = 12'sd100;
        pulse_start();
        feed(2, 1, 8'h05, 8'h00, 16, -1);
        wait_result();
        check("thr80_score", best_score, 80);
        check("thr80_found", peak_found, 0);
        take_result();
        pulse_start();
        feed(0, 3, 8'h07, 8'h00, 16, -1);
        wait_result();
        check("thr112_score", best_score, 112);
        check("thr112_found", peak_found, 1);
        take_result();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
